ten_bt_tx_sched: RTL and testbench
==================================

Name: ten_bt_tx_sched

Overview:
- Transmit scheduler in front of the 10BASE-T Manchester transmitter, clocked by PLL_CLK at 20 MHz.
- Shares the single transmit path between two frame requesters using round-robin arbitration.
- Enforces the inter-packet gap and generates Normal Link Pulses (NLP) whenever the line is idle.
- Drives the serializer's start/select inputs and an NLP strobe that the top level ORs onto TX_P.

Parameters:
- NLP_PERIOD, 320000, cycles between NLP rising edges when idle (16 ms at 20 MHz).
- NLP_WIDTH, 2, cycles nlp is held high (100 ns).
- IPG_CYCLES, 192, idle cycles enforced after every frame (9.6 us).
- FRAME_TIMEOUT, 32768, maximum cycles in FRAME before forced abort.

Ports:
- CLK  in  1  PLL_CLK, 20 MHz.
- RST  in  1  reset; asynchronous, active-low.
- req  in  2  per-requester frame request; level, held until granted.
- gnt  out  2  one-hot grant; high from START through the end of FRAME.
- start  out  1  one-cycle pulse to the serializer to begin a frame.
- sel  out  1  index of the granted requester; valid while gnt != 0.
- ser_done  in  1  one-cycle pulse from the serializer after TP_IDL completes.
- nlp  out  1  link pulse strobe.
- busy  out  1  high when state != IDLE.
- timeout_err  out  1  one-cycle pulse when a frame is aborted by timeout.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE; all outputs 0.
  - nlp_timer=0; ipg_cnt=0; frame_cnt=0; nlp_cnt=0.
  - Round-robin pointer last=1, so req[0] wins the first tie.
- States: IDLE, NLP, START, FRAME, IPG. All outputs are registered.
- nlp_timer rules:
  - Increments in IDLE, NLP and IPG.
  - Saturates at NLP_PERIOD-1.
  - Cleared on entry to NLP.
  - Held at 0 in START and FRAME.
  - nlp_due = (nlp_timer == NLP_PERIOD-1).
- IDLE transitions:
  - If nlp_due: go to NLP. NLP has priority over req.
  - Else if req != 0: go to START.
    - Winner: if both requests are set, the index != last; otherwise the single set bit.
    - Latch sel; set last=sel.
- NLP:
  - nlp=1 for exactly NLP_WIDTH cycles, then IDLE.
  - req is ignored during NLP.
  - Rising edges of nlp are spaced exactly NLP_PERIOD cycles apart while idle.
- START:
  - Lasts exactly 1 cycle: start=1, gnt[sel]=1.
  - Then go to FRAME.
  - Latency: req sampled in IDLE at cycle n gives start=1 at cycle n+1.
- FRAME:
  - gnt[sel] held; frame_cnt increments.
  - On ser_done: gnt=0, go to IPG.
  - If frame_cnt reaches FRAME_TIMEOUT-1 without ser_done: gnt=0, timeout_err=1 for 1 cycle, go to IPG.
  - Dropping req during FRAME has no effect.
- IPG:
  - Stays for IPG_CYCLES cycles, then IDLE.
  - req is ignored.
  - If nlp_due becomes true in IPG, the NLP is taken on the first IDLE cycle.
- ser_done outside FRAME is ignored; no state change.
- ser_done in the same cycle as the timeout limit: treated as normal completion, timeout_err=0.
- Reset asserted mid-frame: gnt/start/nlp drop to 0 immediately (asynchronous); the scheduler returns to IDLE.

Test Plan (bench uses NLP_PERIOD=64, IPG_CYCLES=8, FRAME_TIMEOUT=40):
- Release RST, hold req=0 → nlp high cycles 64-65, next rising edge at 128; busy high only during NLP.
- req=01 pulsed high at idle cycle 10 → start=1 and gnt=01 at cycle 11, sel=0; ser_done at cycle 30 → gnt=0 at 31, busy low at cycle 39 (8 IPG cycles).
- req=11 held continuously → grants alternate 01,10,01,10; each start separated by at least IPG_CYCLES+2 cycles after ser_done.
- req=01 asserted on the same cycle nlp_due is true → NLP is sent first (2 cycles), then start=1 on the following IDLE cycle.
- Grant issued, ser_done never arrives → timeout_err pulses once 40 cycles after entering FRAME; gnt=0; IDLE after 8 more cycles; the nlp_timer restarts from 0.
- RST driven low mid-FRAME → gnt=0 and busy=0 without waiting for a clock edge; after release, nlp first fires 64 cycles later.

Source files
------------

// File: rtl/ten_bt_tx_sched.sv
// ten_bt_tx_sched: shares the 10BASE-T transmit path between two requesters.
// Arbitration is round-robin. The block enforces the inter-packet gap after
// every frame and emits Normal Link Pulses while the line is otherwise idle.
module ten_bt_tx_sched #(
  parameter int unsigned NLP_PERIOD    = 320000,
  parameter int unsigned NLP_WIDTH     = 2,
  parameter int unsigned IPG_CYCLES    = 192,
  parameter int unsigned FRAME_TIMEOUT = 32768
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       start_o,
  output logic       sel_o,
  input  logic       ser_done_i,
  output logic       nlp_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  localparam int unsigned TW = $clog2(NLP_PERIOD + 1);
  localparam int unsigned NW = $clog2(NLP_WIDTH + 1);
  localparam int unsigned IW = $clog2(IPG_CYCLES + 1);
  localparam int unsigned FW = $clog2(FRAME_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NLP   = 3'd1,
    S_START = 3'd2,
    S_FRAME = 3'd3,
    S_IPG   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] nlp_timer_q, nlp_timer_d;
  logic [NW-1:0] nlp_cnt_q, nlp_cnt_d;
  logic [IW-1:0] ipg_cnt_q, ipg_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          last_q, last_d;
  logic          sel_q, sel_d;
  logic          timeout_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          start_q, start_d;
  logic          nlp_q, nlp_d;
  logic          busy_q, busy_d;
  logic          timeout_err_q, timeout_err_d;
  logic          nlp_due;

  assign nlp_due = (nlp_timer_q == TW'(NLP_PERIOD - 1));

  // State register plus the grant bookkeeping that travels with it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
    end
  end

  // Next-state logic: link pulses beat requests, then round-robin pick
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (nlp_due) begin
          state_d = S_NLP;
        end else if (req_i != 2'b00) begin
          state_d = S_START;
          if (req_i == 2'b11) begin
            sel_d = ~last_q;
          end else begin
            sel_d = req_i[1];
          end
          last_d = sel_d;
        end
      end
      S_NLP: begin
        if (nlp_cnt_q == NW'(NLP_WIDTH - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_FRAME;
      end
      S_FRAME: begin
        if (ser_done_i) begin
          state_d = S_IPG;
        end else if (frame_cnt_q == FW'(FRAME_TIMEOUT - 1)) begin
          state_d   = S_IPG;
          timeout_d = 1'b1;
        end
      end
      S_IPG: begin
        if (ipg_cnt_q == IW'(IPG_CYCLES - 1)) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter next values; the link timer measures quiet time since the last pulse or frame
  always_comb begin
    nlp_timer_d = nlp_timer_q + TW'(1);
    if (state_q == S_IDLE && state_d == S_NLP) begin
      nlp_timer_d = '0;
    end else if (state_q == S_START || state_q == S_FRAME || state_d == S_START) begin
      nlp_timer_d = '0;
    end else if (nlp_due) begin
      nlp_timer_d = nlp_timer_q;
    end
    nlp_cnt_d   = (state_q == S_NLP && state_d == S_NLP) ? nlp_cnt_q + NW'(1) : '0;
    ipg_cnt_d   = (state_q == S_IPG && state_d == S_IPG) ? ipg_cnt_q + IW'(1) : '0;
    frame_cnt_d = (state_q == S_FRAME && state_d == S_FRAME) ? frame_cnt_q + FW'(1) : '0;
  end

  // Output decode from the upcoming state so every output leaves a flop
  always_comb begin
    gnt_d         = 2'b00;
    start_d       = (state_d == S_START);
    nlp_d         = (state_d == S_NLP);
    busy_d        = (state_d != S_IDLE);
    timeout_err_d = timeout_d;
    if (state_d == S_START || state_d == S_FRAME) begin
      gnt_d = sel_d ? 2'b10 : 2'b01;
    end
  end

  // Counter and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nlp_timer_q   <= '0;
      nlp_cnt_q     <= '0;
      ipg_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      gnt_q         <= 2'b00;
      start_q       <= 1'b0;
      nlp_q         <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      nlp_timer_q   <= nlp_timer_d;
      nlp_cnt_q     <= nlp_cnt_d;
      ipg_cnt_q     <= ipg_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      gnt_q         <= gnt_d;
      start_q       <= start_d;
      nlp_q         <= nlp_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign start_o       = start_q;
  assign sel_o         = sel_q;
  assign nlp_o         = nlp_q;
  assign busy_o        = busy_q;
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_ten_bt_tx_sched.sv
// tb_ten_bt_tx_sched: directed bench for the 10BASE-T transmit scheduler with a
// timestamp-based reference model checked against the DUT every cycle.
module tb_ten_bt_tx_sched;

  localparam int P = 64;
  localparam int W = 2;
  localparam int G = 8;
  localparam int T = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic       serDone = 1'b0;
  logic [1:0] gnt;
  logic       start, sel, nlp, busy, tmo;

  int checks = 0;
  int failures = 0;

  typedef enum int {M_IDLE, M_NLP, M_START, M_FRAME, M_IPG} phase_t;

  phase_t     mPh;
  int         cyc, phaseStart, quietZero, lastWin, mSel;
  logic [1:0] eGnt;
  logic       eStart, eNlp, eBusy, eTmo;

  always #5 clk = ~clk;

  ten_bt_tx_sched #(
    .NLP_PERIOD(P), .NLP_WIDTH(W), .IPG_CYCLES(G), .FRAME_TIMEOUT(T)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .start_o(start),
    .sel_o(sel), .ser_done_i(serDone), .nlp_o(nlp), .busy_o(busy),
    .timeout_err_o(tmo)
  );

  // Record one comparison and report it if it disagrees
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic d);
    req = r;
    serDone = d;
  endtask

  // Derive expected outputs from the current model phase
  function automatic void publish();
    eGnt   = (mPh == M_START || mPh == M_FRAME) ? ((mSel == 1) ? 2'b10 : 2'b01) : 2'b00;
    eStart = (mPh == M_START);
    eNlp   = (mPh == M_NLP);
    eBusy  = (mPh != M_IDLE);
  endfunction

  function automatic void modelReset();
    mPh = M_IDLE; cyc = 0; phaseStart = 0; quietZero = 0;
    lastWin = 1; mSel = 0; eTmo = 1'b0;
    publish();
  endfunction

  // One clock of the scheduler rules, expressed with cycle timestamps
  function automatic void modelStep();
    phase_t nxt = mPh;
    logic   t = 1'b0;
    case (mPh)
      M_IDLE: begin
        if (cyc - quietZero >= P - 1) begin
          nxt = M_NLP; quietZero = cyc + 1; phaseStart = cyc + 1;
        end else if (req != 2'b00) begin
          if (req == 2'b11) mSel = 1 - lastWin;
          else mSel = req[1] ? 1 : 0;
          lastWin = mSel; nxt = M_START; phaseStart = cyc + 1;
        end
      end
      M_NLP: if (cyc + 1 - phaseStart >= W) nxt = M_IDLE;
      M_START: begin nxt = M_FRAME; phaseStart = cyc + 1; end
      M_FRAME: begin
        if (serDone) begin
          nxt = M_IPG; quietZero = cyc + 1; phaseStart = cyc + 1;
        end else if (cyc + 1 - phaseStart >= T) begin
          nxt = M_IPG; t = 1'b1; quietZero = cyc + 1; phaseStart = cyc + 1;
        end
      end
      M_IPG: if (cyc + 1 - phaseStart >= G) nxt = M_IDLE;
      default: nxt = M_IDLE;
    endcase
    mPh = nxt;
    cyc++;
    eTmo = t;
    publish();
  endfunction

  // Reference model advances on every clock and follows the async reset
  initial begin
    modelReset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) modelReset();
      else modelStep();
    end
  end

  // Compare DUT against the model in the middle of every cycle
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("gnt", gnt, eGnt);
      checkOutput("start", start, eStart);
      checkOutput("nlp", nlp, eNlp);
      checkOutput("busy", busy, eBusy);
      checkOutput("timeout_err", tmo, eTmo);
      if (eGnt != 2'b00) checkOutput("sel", sel, mSel);
    end
  end

  task automatic stepTo(input int target);
    int guard = 0;
    while (cyc < target && guard < 20000) begin
      @(posedge clk);
      #2;
      guard++;
    end
  endtask

  task automatic applyReset();
    @(posedge clk);
    #4 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic waitStart(output int at, output logic [1:0] g);
    int n = 0;
    while (!start && n < 200) begin
      @(posedge clk);
      #2;
      n++;
    end
    checkOutput("startSeen", start, 1);
    at = cyc;
    g = gnt;
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios with hand-computed expectations
  initial begin
    int sc, prevDone;
    logic [1:0] g;
    logic [1:0] expG [4];
    expG[0] = 2'b01; expG[1] = 2'b10; expG[2] = 2'b01; expG[3] = 2'b10;

    $display("[TB] idle link pulses");
    applyStimulus(2'b00, 1'b0);
    applyReset();
    checkOutput("rstGnt", gnt, 0);
    checkOutput("rstBusy", busy, 0);
    stepTo(63);  checkOutput("nlp63", nlp, 0);
    stepTo(64);  checkOutput("nlp64", nlp, 1); checkOutput("busy64", busy, 1);
    stepTo(65);  checkOutput("nlp65", nlp, 1);
    stepTo(66);  checkOutput("nlp66", nlp, 0); checkOutput("busy66", busy, 0);
    stepTo(127); checkOutput("nlp127", nlp, 0);
    stepTo(128); checkOutput("nlp128", nlp, 1);

    $display("[TB] single frame");
    applyReset();
    stepTo(10); applyStimulus(2'b01, 1'b0);
    stepTo(11); checkOutput("start11", start, 1); checkOutput("gnt11", gnt, 1);
    checkOutput("sel11", sel, 0);
    applyStimulus(2'b00, 1'b0);
    stepTo(30); applyStimulus(2'b00, 1'b1);
    stepTo(31); applyStimulus(2'b00, 1'b0);
    checkOutput("gnt31", gnt, 0); checkOutput("busy31", busy, 1);
    stepTo(38); checkOutput("busy38", busy, 1);
    stepTo(39); checkOutput("busy39", busy, 0);

    $display("[TB] round robin");
    applyStimulus(2'b11, 1'b0);
    applyReset();
    prevDone = 0;
    for (int k = 0; k < 4; k++) begin
      waitStart(sc, g);
      checkOutput($sformatf("rrGnt%0d", k), g, expG[k]);
      if (k > 0) checkOutput("rrSpacing", sc - prevDone, G + 2);
      stepTo(sc + 5);
      applyStimulus(2'b11, 1'b1);
      prevDone = cyc;
      stepTo(cyc + 1);
      applyStimulus(2'b11, 1'b0);
    end

    $display("[TB] link pulse beats request");
    applyStimulus(2'b00, 1'b0);
    applyReset();
    stepTo(63); applyStimulus(2'b01, 1'b0);
    stepTo(64); checkOutput("nlpFirst64", nlp, 1); checkOutput("noStart64", start, 0);
    stepTo(65); checkOutput("nlpFirst65", nlp, 1);
    stepTo(66); checkOutput("idle66", busy, 0);
    stepTo(67); checkOutput("start67", start, 1); checkOutput("gnt67", gnt, 1);
    applyStimulus(2'b00, 1'b0);

    $display("[TB] frame timeout");
    applyReset();
    stepTo(5); applyStimulus(2'b01, 1'b0);
    stepTo(6); applyStimulus(2'b00, 1'b0);
    stepTo(46); checkOutput("gnt46", gnt, 1); checkOutput("tmo46", tmo, 0);
    stepTo(47); checkOutput("tmo47", tmo, 1); checkOutput("gnt47", gnt, 0);
    stepTo(48); checkOutput("tmo48", tmo, 0);
    stepTo(50); applyStimulus(2'b00, 1'b1);
    stepTo(51); applyStimulus(2'b00, 1'b0); checkOutput("busy51", busy, 1);
    stepTo(54); checkOutput("busy54", busy, 1);
    stepTo(55); checkOutput("busy55", busy, 0);
    stepTo(60); applyStimulus(2'b00, 1'b1);
    stepTo(61); applyStimulus(2'b00, 1'b0); checkOutput("busy61", busy, 0);
    stepTo(110); checkOutput("nlp110", nlp, 0);
    stepTo(111); checkOutput("nlp111", nlp, 1);

    $display("[TB] done on the timeout cycle");
    applyReset();
    stepTo(5); applyStimulus(2'b01, 1'b0);
    stepTo(6); applyStimulus(2'b00, 1'b0);
    stepTo(46); applyStimulus(2'b00, 1'b1);
    stepTo(47); applyStimulus(2'b00, 1'b0);
    checkOutput("tmoDone47", tmo, 0); checkOutput("gntDone47", gnt, 0);
    stepTo(55); checkOutput("busyDone55", busy, 0);

    $display("[TB] reset mid-frame");
    applyReset();
    stepTo(5); applyStimulus(2'b01, 1'b0);
    stepTo(6); applyStimulus(2'b00, 1'b0);
    stepTo(20); checkOutput("gnt20", gnt, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncGnt", gnt, 0);
    checkOutput("asyncBusy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    stepTo(63); checkOutput("postRst63", nlp, 0);
    stepTo(64); checkOutput("postRst64", nlp, 1);
    stepTo(66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
